sync_steer: RTL and testbench
=============================

SYNC_STEER -- requirements
Module: sync_steer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of flop stages on every asynchronous input; legal values are 1 to 3.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have the port init_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the port A, input, 2 bits: dual-rail source datum. 00 means NULL, 01 means DATA0, 10 means DATA1, 11 is illegal.
REQ-005 The block SHALL have the port ACOMP, output, 1 bit: source completion. 1 means the datum was consumed and the source must return NULL.
REQ-006 The block SHALL have the port selectin, input, 4 bits: one-hot destination select; 0000 is NULL.
REQ-007 The block SHALL have the port selectinCOMP, output, 1 bit: completion for selectin.
REQ-008 The block SHALL have the ports Ss, Ts, Us and Vs, output, 2 bits each: dual-rail destination channels 0 to 3.
REQ-009 The block SHALL have the ports SCOMP, TCOMP, UCOMP and VCOMP, input, 1 bit each: completion from the destination on each channel.
REQ-010 The block SHALL have the port selectout, output, 4 bits: the forwarded one-hot select.
REQ-011 The block SHALL have the port selectoutCOMP, input, 1 bit: completion for selectout.

Function
REQ-012 The block SHALL pass A, selectin, the four channel COMPs and selectoutCOMP through SYNC_STAGES flop stages; the FSM SHALL use only the synchronized copies.
REQ-013 The FSM SHALL have three states: IDLE, FWD and ACK.
REQ-014 IDLE: all channel outputs are 00, selectout is 0000, ACOMP is 0 and selectinCOMP is 0.
REQ-015 IDLE to FWD SHALL occur when all of the following hold: synchronized A is 01 or 10; synchronized selectin has exactly one bit set; the selected channel's COMP is 0; selectoutCOMP is 0.
REQ-016 On the IDLE to FWD transition, the block SHALL register A and selectin.
REQ-017 FWD: the registered datum SHALL drive only the selected channel; the other three channels SHALL be 00; selectout SHALL equal the registered select.
REQ-018 FWD to ACK SHALL occur when the selected channel's COMP is 1 and selectoutCOMP is 1.
REQ-019 ACK: all channel outputs SHALL be 00, selectout SHALL be 0000, and ACOMP and selectinCOMP SHALL both be 1.
REQ-020 ACK to IDLE SHALL occur when synchronized A is 00, selectin is 0000, the selected COMP is 0 and selectoutCOMP is 0.
REQ-021 All outputs SHALL come directly from flops; latency from an A/selectin edge to channel DATA is SYNC_STAGES+1 cycles.
REQ-022 If A is 11, or selectin has more than one bit set, the FSM SHALL remain in IDLE and drive no output.
REQ-023 A change of A or selectin during FWD SHALL be ignored; the registered values are held until ACK.
REQ-024 In ACK, a COMP from a non-selected channel SHALL have no effect.
REQ-025 If IDLE exit conditions and ACK return conditions are both presented, only the transition for the current state SHALL apply; at most one transition occurs per cycle.

Reset
REQ-026 While init_n is 0, the block SHALL asynchronously force the following, independent of clk:
- FSM to IDLE;
- all synchronizer stages to 0;
- the registered datum and select to 0;
- all outputs to NULL or 0.
REQ-027 Assertion of init_n in FWD or ACK SHALL immediately drive every channel to 00 and ACOMP to 0.
REQ-028 init_n deassertion SHALL be synchronized to clk; the first transition is permitted no earlier than the second clk edge after release.

Configuration
REQ-029 With STEER_ERR_EN defined, the block SHALL add output err (1 bit).
REQ-030 With STEER_ERR_EN defined, err SHALL set one cycle after the condition of REQ-022 is seen in IDLE, stay set until reset, and leave REQ-022 behaviour unchanged.
REQ-031 With STEER_ERR_EN undefined, the err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 SYNC_STAGES=2; A=10, selectin=0100, all COMP=0 -> Us=10 three cycles later; Ss, Ts and Vs stay 00; selectout=0100.
REQ-033 After REQ-032, UCOMP=1 and selectoutCOMP=1 -> Us=00, ACOMP=1, selectinCOMP=1; then A=00, selectin=0000, UCOMP=0, selectoutCOMP=0 -> ACOMP=0 and the FSM is back in IDLE.
REQ-034 In FWD on channel 0, A changes to 01 and TCOMP pulses -> Ss holds its value; no ACK until SCOMP=1.
REQ-035 A=11 or selectin=0011 -> all channels stay 00 and ACOMP stays 0; with STEER_ERR_EN defined, err=1 and stays 1 until init_n=0.
REQ-036 init_n=0 asserted mid-FWD with Vs=01 -> Vs=00 and ACOMP=0 with no clk edge; after release, a new transfer on channel 1 completes normally.
REQ-037 Back-to-back transfers: channel sequence 0, 3, 0, 2 with random COMP delays of 0 to 5 cycles -> each datum appears on exactly the selected channel, in order, with no duplication.

Source files
------------

// File: rtl/sync_steer.sv
// Dual-rail one-of-four steering stage with input synchronizers.
// Define STEER_ERR_EN to add the sticky illegal-input flag output err.
module sync_steer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic [1:0] A,
  output logic       ACOMP,
  input  logic [3:0] selectin,
  output logic       selectinCOMP,
  output logic [1:0] Ss,
  output logic [1:0] Ts,
  output logic [1:0] Us,
  output logic [1:0] Vs,
  input  logic       SCOMP,
  input  logic       TCOMP,
  input  logic       UCOMP,
  input  logic       VCOMP,
  output logic [3:0] selectout,
  input  logic       selectoutCOMP
`ifdef STEER_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {IDLE, FWD, ACK} state_t;

  localparam int W = 11;

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] raw;
  logic [1:0]   rst_q;
  logic         run;

  logic [1:0] a_s;
  logic [3:0] sel_s;
  logic [3:0] comp_s;
  logic       so_s;

  state_t     state_q, state_d;
  logic [1:0] dat_q, dat_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] ch_q, ch_d;
  logic [3:0] selout_q, selout_d;
  logic       acomp_q, acomp_d;
  logic       sicomp_q, sicomp_d;

  logic a_ok, sel_one, sel_bad, go_idle, go_fwd, go_ack;

  assign raw = {selectoutCOMP, VCOMP, UCOMP, TCOMP, SCOMP, selectin, A};

  // Release is delayed two edges so no transition races reset removal
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) rst_q <= '0;
    else         rst_q <= {rst_q[0], 1'b1};
  end

  assign run = rst_q[1];

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign a_s    = sync_q[SYNC_STAGES-1][1:0];
  assign sel_s  = sync_q[SYNC_STAGES-1][5:2];
  assign comp_s = sync_q[SYNC_STAGES-1][9:6];
  assign so_s   = sync_q[SYNC_STAGES-1][10];

  assign a_ok    = (a_s == 2'b01) || (a_s == 2'b10);
  assign sel_one = (sel_s != 4'b0) && ((sel_s & (sel_s - 4'd1)) == 4'b0);
  assign sel_bad = (sel_s != 4'b0) && !sel_one;

  assign go_fwd  = run && a_ok && sel_one &&
                   ((comp_s & sel_s) == 4'b0) && !so_s;
  assign go_ack  = ((comp_s & sel_q) != 4'b0) && so_s;
  assign go_idle = (a_s == 2'b00) && (sel_s == 4'b0) &&
                   ((comp_s & sel_q) == 4'b0) && !so_s;

  always_comb begin
    state_d  = state_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    ch_d     = '0;
    selout_d = '0;
    acomp_d  = 1'b0;
    sicomp_d = 1'b0;
    case (state_q)
      IDLE: if (go_fwd) begin
        state_d = FWD;
        dat_d   = a_s;
        sel_d   = sel_s;
      end
      FWD:     if (go_ack)  state_d = ACK;
      ACK:     if (go_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they leave flops directly
    case (state_d)
      FWD: begin
        for (int i = 0; i < 4; i++)
          ch_d[2*i +: 2] = sel_d[i] ? dat_d : 2'b00;
        selout_d = sel_d;
      end
      ACK: begin
        acomp_d  = 1'b1;
        sicomp_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q  <= IDLE;
      dat_q    <= '0;
      sel_q    <= '0;
      ch_q     <= '0;
      selout_q <= '0;
      acomp_q  <= 1'b0;
      sicomp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      ch_q     <= ch_d;
      selout_q <= selout_d;
      acomp_q  <= acomp_d;
      sicomp_q <= sicomp_d;
    end
  end

  assign Ss           = ch_q[1:0];
  assign Ts           = ch_q[3:2];
  assign Us           = ch_q[5:4];
  assign Vs           = ch_q[7:6];
  assign selectout    = selout_q;
  assign ACOMP        = acomp_q;
  assign selectinCOMP = sicomp_q;

`ifdef STEER_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q ||
                 ((state_q == IDLE) && run && ((a_s == 2'b11) || sel_bad));

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_bad;
  assign unused_bad = sel_bad;
`endif

endmodule

// File: tb/tb_sync_steer.sv
// Directed self-checking bench for sync_steer (SYNC_STAGES=2).
module tb_sync_steer;

  logic       clk = 1'b0;
  logic       init_n;
  logic [1:0] A;
  logic [3:0] selectin;
  logic [3:0] comp;
  logic       selectoutCOMP;
  logic       ACOMP, selectinCOMP;
  logic [1:0] Ss, Ts, Us, Vs;
  logic [3:0] selectout;
`ifdef STEER_ERR_EN
  logic       err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sync_steer #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .init_n       (init_n),
    .A            (A),
    .ACOMP        (ACOMP),
    .selectin     (selectin),
    .selectinCOMP (selectinCOMP),
    .Ss           (Ss),
    .Ts           (Ts),
    .Us           (Us),
    .Vs           (Vs),
    .SCOMP        (comp[0]),
    .TCOMP        (comp[1]),
    .UCOMP        (comp[2]),
    .VCOMP        (comp[3]),
    .selectout    (selectout),
    .selectoutCOMP(selectoutCOMP)
`ifdef STEER_ERR_EN
    ,
    .err          (err)
`endif
  );

  wire [7:0] bus = {Vs, Us, Ts, Ss};

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int c, input logic [1:0] d, input int dly);
    logic [7:0] e;
    e = 8'(d) << (2 * c);
    A        = d;
    selectin = 4'(1 << c);
    step(2);
    chk("lat_early", bus, 8'h00);
    step(1);
    chk("data", bus, e);
    chk("selout", {4'h0, selectout}, {4'h0, 4'(1 << c)});
    chk("no_ack", {6'h0, ACOMP, selectinCOMP}, 8'h00);
    step(dly);
    chk("hold", bus, e);
    comp[c]       = 1'b1;
    selectoutCOMP = 1'b1;
    step(2);
    chk("hold2", bus, e);
    step(1);
    chk("ack_bus", bus, 8'h00);
    chk("ack_sel", {4'h0, selectout}, 8'h00);
    chk("ack", {6'h0, ACOMP, selectinCOMP}, 8'h03);
    A             = 2'b00;
    selectin      = 4'b0;
    comp          = 4'b0;
    selectoutCOMP = 1'b0;
    step(3);
    chk("idle", {6'h0, ACOMP, selectinCOMP}, 8'h00);
  endtask

  initial begin
    init_n        = 1'b0;
    A             = 2'b00;
    selectin      = 4'b0;
    comp          = 4'b0;
    selectoutCOMP = 1'b0;
    #3;
    chk("rst_bus", bus, 8'h00);
    chk("rst_ctl", {2'b0, ACOMP, selectinCOMP, selectout}, 8'h00);
    step(2);
    init_n = 1'b1;
    step(3);

    // basic transfer on U, full handshake
    xfer(2, 2'b10, 0);

    // FWD on S ignores A change and a foreign COMP
    A        = 2'b10;
    selectin = 4'b0001;
    step(3);
    chk("s_data", bus, 8'h02);
    A             = 2'b01;
    comp[1]       = 1'b1;
    selectoutCOMP = 1'b1;
    step(4);
    chk("s_hold", bus, 8'h02);
    chk("s_noack", {7'h0, ACOMP}, 8'h00);
    comp[1] = 1'b0;
    comp[0] = 1'b1;
    step(3);
    chk("s_ack", {6'h0, ACOMP, selectinCOMP}, 8'h03);
    A             = 2'b00;
    selectin      = 4'b0;
    comp          = 4'b0;
    selectoutCOMP = 1'b0;
    step(3);
    chk("s_idle", {7'h0, ACOMP}, 8'h00);

    // illegal inputs
    A        = 2'b11;
    selectin = 4'b0100;
    step(4);
    chk("ill_a_bus", bus, 8'h00);
    chk("ill_a_ack", {7'h0, ACOMP}, 8'h00);
`ifdef STEER_ERR_EN
    chk("err_a", {7'h0, err}, 8'h01);
`endif
    A        = 2'b10;
    selectin = 4'b0011;
    step(4);
    chk("ill_s_bus", bus, 8'h00);
    chk("ill_s_ack", {7'h0, ACOMP}, 8'h00);
    A        = 2'b00;
    selectin = 4'b0;
    step(3);
`ifdef STEER_ERR_EN
    chk("err_hold", {7'h0, err}, 8'h01);
`endif

    // async reset mid-FWD on V
    A        = 2'b01;
    selectin = 4'b1000;
    step(3);
    chk("v_data", bus, 8'h40);
    #2 init_n = 1'b0;
    #1;
    chk("arst_bus", bus, 8'h00);
    chk("arst_ack", {7'h0, ACOMP}, 8'h00);
`ifdef STEER_ERR_EN
    chk("err_clr", {7'h0, err}, 8'h00);
`endif
    A        = 2'b00;
    selectin = 4'b0;
    step(1);
    init_n = 1'b1;
    xfer(1, 2'b01, 1);

    // back-to-back with random completion delays
    xfer(0, 2'b10, int'($urandom_range(0, 5)));
    xfer(3, 2'b01, int'($urandom_range(0, 5)));
    xfer(0, 2'b01, int'($urandom_range(0, 5)));
    xfer(2, 2'b10, int'($urandom_range(0, 5)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
